// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
  logic        DMemReq;
  logic        DMemWe;
  logic [31:0] DMemAddr;
  logic [31:0] DMemWData;
  logic [3:0]  DMemBE;
  logic        DMemAck;
  logic [31:0] DMemRData;

  modport master (
    output DMemReq, DMemWe, DMemAddr, DMemWData, DMemBE,
    input  DMemAck, DMemRData
  );

  modport slave (
    input  DMemReq, DMemWe, DMemAddr, DMemWData, DMemBE,
    output DMemAck, DMemRData
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage with req/ack data-memory access, load formatting and the MEM/WB register.
// Optional macro MEM_ALIGN_CHECK_EN: reject misaligned half/word accesses without a bus request.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Valid_EXMEM_MEM,
  input  logic               MemRead_EXMEM_MEM,
  input  logic               MemWrite_EXMEM_MEM,
  input  logic [1:0]         MemSize_EXMEM_MEM,
  input  logic               LoadUnsigned_EXMEM_MEM,
  input  logic [31:0]        ALUResult_EXMEM_MEM,
  input  logic [31:0]        WriteData_EXMEM_MEM,
  input  logic [1:0]         MemReg_EXMEM_MEM,
  input  logic               RegWrite_EXMEM_MEM,
  input  logic [4:0]         WriteReg_EXMEM_MEM,
  input  logic [31:0]        PC2ndAdder_EXMEM_MEM,
  input  logic               Flush_MEM,
  mem_access_stage_if.master dmem,
  output logic               Stall_MEM,
  output logic               BusErr,
  output logic               MisalignErr_MEMWB,
  output logic [1:0]         MemReg_MEMWB_WRITE,
  output logic [31:0]        LoadData_MEMWB_WRITE,
  output logic [31:0]        ALUResult_MEMWB_WRITE,
  output logic [31:0]        PC2ndAdder_MEMWB_Write,
  output logic               RegWrite_MEMWB_WRITE,
  output logic [4:0]         WriteReg_MEMWB_WRITE
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             flush_q, err_q, mis_q;
  logic [31:0]      load_q;

  logic        sz_byte, sz_half, is_load, is_mem, misalign;
  logic        timeout, wb_load, bubble, req;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt, wdata_rep;
  logic [3:0]  be_st;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sz_byte  = (MemSize_EXMEM_MEM == 2'b10);
    sz_half  = (MemSize_EXMEM_MEM == 2'b01);
    is_load  = MemRead_EXMEM_MEM & ~MemWrite_EXMEM_MEM;
    is_mem   = Valid_EXMEM_MEM & (MemRead_EXMEM_MEM | MemWrite_EXMEM_MEM) & ~Flush_MEM;
`ifdef MEM_ALIGN_CHECK_EN
    misalign = (sz_half & ALUResult_EXMEM_MEM[0]) |
               (~sz_byte & ~sz_half & (ALUResult_EXMEM_MEM[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif

    be_st     = 4'b1111;
    wdata_rep = WriteData_EXMEM_MEM;
    if (sz_byte) begin
      be_st     = 4'b0001 << ALUResult_EXMEM_MEM[1:0];
      wdata_rep = {4{WriteData_EXMEM_MEM[7:0]}};
    end else if (sz_half) begin
      be_st     = ALUResult_EXMEM_MEM[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{WriteData_EXMEM_MEM[15:0]}};
    end

    case (ALUResult_EXMEM_MEM[1:0])
      2'd0:    byte_sel = dmem.DMemRData[7:0];
      2'd1:    byte_sel = dmem.DMemRData[15:8];
      2'd2:    byte_sel = dmem.DMemRData[23:16];
      default: byte_sel = dmem.DMemRData[31:24];
    endcase
    half_sel = ALUResult_EXMEM_MEM[1] ? dmem.DMemRData[31:16] : dmem.DMemRData[15:0];

    if (sz_byte)
      load_fmt = LoadUnsigned_EXMEM_MEM ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    else if (sz_half)
      load_fmt = LoadUnsigned_EXMEM_MEM ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
    else
      load_fmt = dmem.DMemRData;
  end

  assign req            = (state == ACCESS);
  assign timeout        = req & ~dmem.DMemAck & (cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign dmem.DMemReq   = req;
  assign dmem.DMemWe    = req & MemWrite_EXMEM_MEM;
  assign dmem.DMemBE    = req ? (MemWrite_EXMEM_MEM ? be_st : 4'b1111) : 4'b0000;
  assign dmem.DMemAddr  = {ALUResult_EXMEM_MEM[31:2], 2'b00};
  assign dmem.DMemWData = wdata_rep;

  always_comb begin
    state_nxt = state;
    Stall_MEM = 1'b0;
    wb_load   = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          Stall_MEM = 1'b1;
          state_nxt = misalign ? DONE : ACCESS;
        end else begin
          wb_load = 1'b1;
        end
      end
      ACCESS: begin
        Stall_MEM = 1'b1;
        if (dmem.DMemAck || timeout) state_nxt = DONE;
      end
      DONE: begin
        wb_load   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A flush seen at any point of an access turns its DONE write-back into a bubble.
    bubble = (state == DONE) ? (flush_q | Flush_MEM) : (~Valid_EXMEM_MEM | Flush_MEM);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      cnt     <= '0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      load_q  <= 32'h0;
      BusErr  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          cnt     <= '0;
          flush_q <= 1'b0;
          err_q   <= 1'b0;
          mis_q   <= is_mem & misalign;
          load_q  <= 32'h0;
        end
        ACCESS: begin
          flush_q <= flush_q | Flush_MEM;
          cnt     <= cnt + 1'b1;
          if (dmem.DMemAck) begin
            load_q <= is_load ? load_fmt : 32'h0;
          end else if (timeout) begin
            load_q <= 32'h0;
            err_q  <= 1'b1;
            BusErr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      MemReg_MEMWB_WRITE     <= 2'b00;
      LoadData_MEMWB_WRITE   <= 32'h0;
      ALUResult_MEMWB_WRITE  <= 32'h0;
      PC2ndAdder_MEMWB_Write <= 32'h0;
      RegWrite_MEMWB_WRITE   <= 1'b0;
      WriteReg_MEMWB_WRITE   <= 5'd0;
      MisalignErr_MEMWB      <= 1'b0;
    end else if (wb_load) begin
      if (bubble) begin
        MemReg_MEMWB_WRITE     <= 2'b00;
        LoadData_MEMWB_WRITE   <= 32'h0;
        ALUResult_MEMWB_WRITE  <= 32'h0;
        PC2ndAdder_MEMWB_Write <= 32'h0;
        RegWrite_MEMWB_WRITE   <= 1'b0;
        WriteReg_MEMWB_WRITE   <= 5'd0;
        MisalignErr_MEMWB      <= 1'b0;
      end else begin
        MemReg_MEMWB_WRITE     <= MemReg_EXMEM_MEM;
        LoadData_MEMWB_WRITE   <= (state == DONE) ? load_q : 32'h0;
        ALUResult_MEMWB_WRITE  <= ALUResult_EXMEM_MEM;
        PC2ndAdder_MEMWB_Write <= PC2ndAdder_EXMEM_MEM;
        RegWrite_MEMWB_WRITE   <= RegWrite_EXMEM_MEM & ~((state == DONE) & (err_q | mis_q));
        WriteReg_MEMWB_WRITE   <= WriteReg_EXMEM_MEM;
        MisalignErr_MEMWB      <= (state == DONE) & mis_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: ALU pass-through, loads, stores, timeout, flush, reset.
module tb_mem_access_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, LoadUnsigned = 1'b0;
  logic [1:0]  MemSize = 2'b00, MemReg = 2'b00;
  logic [31:0] ALUResult = 32'h0, WriteData = 32'h0, PC2ndAdder = 32'h0;
  logic        RegWrite = 1'b0, Flush = 1'b0;
  logic [4:0]  WriteReg = 5'd0;

  logic        Stall_MEM, BusErr, MisalignErr_MEMWB, RegWrite_wb;
  logic [1:0]  MemReg_wb;
  logic [31:0] LoadData_wb, ALUResult_wb, PC_wb;
  logic [4:0]  WriteReg_wb;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage_if dif();

  mem_access_stage #(.ACK_TIMEOUT(15)) dut (
    .Clk                    (Clk),
    .Rst                    (Rst),
    .Valid_EXMEM_MEM        (Valid),
    .MemRead_EXMEM_MEM      (MemRead),
    .MemWrite_EXMEM_MEM     (MemWrite),
    .MemSize_EXMEM_MEM      (MemSize),
    .LoadUnsigned_EXMEM_MEM (LoadUnsigned),
    .ALUResult_EXMEM_MEM    (ALUResult),
    .WriteData_EXMEM_MEM    (WriteData),
    .MemReg_EXMEM_MEM       (MemReg),
    .RegWrite_EXMEM_MEM     (RegWrite),
    .WriteReg_EXMEM_MEM     (WriteReg),
    .PC2ndAdder_EXMEM_MEM   (PC2ndAdder),
    .Flush_MEM              (Flush),
    .dmem                   (dif),
    .Stall_MEM              (Stall_MEM),
    .BusErr                 (BusErr),
    .MisalignErr_MEMWB      (MisalignErr_MEMWB),
    .MemReg_MEMWB_WRITE     (MemReg_wb),
    .LoadData_MEMWB_WRITE   (LoadData_wb),
    .ALUResult_MEMWB_WRITE  (ALUResult_wb),
    .PC2ndAdder_MEMWB_Write (PC_wb),
    .RegWrite_MEMWB_WRITE   (RegWrite_wb),
    .WriteReg_MEMWB_WRITE   (WriteReg_wb)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] alu, input logic [31:0] wd,
                        input logic rw, input logic [4:0] wreg, input logic [31:0] pc);
    Valid = v; MemRead = rd; MemWrite = wr; MemSize = sz; LoadUnsigned = uns;
    ALUResult = alu; WriteData = wd; RegWrite = rw; WriteReg = wreg; PC2ndAdder = pc;
    MemReg = rd ? 2'b01 : 2'b00;
  endtask

  // Runs the op currently on the inputs until the stage stops stalling; ack_delay < 0 means no ack.
  task automatic run_op(input int ack_delay, input logic [31:0] rdata, input bit flush_access,
                        output int stalls, output int reqs, output bit stable,
                        output logic [31:0] addr0, output logic [31:0] wd0,
                        output logic [3:0] be0, output logic we0);
    bit done = 1'b0;
    stalls = 0; reqs = 0; stable = 1'b1;
    addr0 = 32'h0; wd0 = 32'h0; be0 = 4'h0; we0 = 1'b0;
    dif.DMemRData = rdata;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge Clk);
      if (Stall_MEM) stalls++; else done = 1'b1;
      if (dif.DMemReq) begin
        if (reqs == 0) begin
          addr0 = dif.DMemAddr; wd0 = dif.DMemWData; be0 = dif.DMemBE; we0 = dif.DMemWe;
        end else if (dif.DMemAddr !== addr0 || dif.DMemWData !== wd0 ||
                     dif.DMemBE !== be0 || dif.DMemWe !== we0) begin
          stable = 1'b0;
        end
        reqs++;
        if (reqs == ack_delay + 1) dif.DMemAck = 1'b1;
        if (flush_access && reqs == 1) Flush = 1'b1;
      end
      if (!done) begin
        @(posedge Clk); #1;
        dif.DMemAck = 1'b0;
        Flush = 1'b0;
      end
    end
    check("op_terminates", {31'h0, done}, 32'h1);
    @(posedge Clk); #1;
    set_op(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
  endtask

  int          stalls, reqs;
  bit          stable;
  logic [31:0] addr0, wd0;
  logic [3:0]  be0;
  logic        we0;

  initial begin
    dif.DMemAck   = 1'b0;
    dif.DMemRData = 32'h0;
    #2;
    check("rst_regwrite", {31'h0, RegWrite_wb}, 32'h0);
    check("rst_aluresult", ALUResult_wb, 32'h0);
    check("rst_loaddata", LoadData_wb, 32'h0);
    check("rst_req_be_we_buserr_mis", {27'h0, dif.DMemReq, dif.DMemBE == 4'h0, dif.DMemWe, BusErr, MisalignErr_MEMWB}, 32'h8);
    @(posedge Clk); #1;
    Rst = 1'b0;

    // ALU op: one-cycle latency, no stall
    set_op(1, 0, 0, 2'b00, 0, 32'h0000_1234, 32'h0, 1, 5'd8, 32'h44);
    run_op(0, 32'h0, 0, stalls, reqs, stable, addr0, wd0, be0, we0);
    check("alu_stalls", stalls, 0);
    check("alu_result", ALUResult_wb, 32'h1234);
    check("alu_regwrite_wreg", {RegWrite_wb, WriteReg_wb}, {1'b1, 5'd8});
    check("alu_pc_loaddata", PC_wb ^ LoadData_wb, 32'h44);

    // lb 0x103 signed
    set_op(1, 1, 0, 2'b10, 0, 32'h0000_0103, 32'h0, 1, 5'd9, 32'h48);
    run_op(0, 32'h80FF_1122, 0, stalls, reqs, stable, addr0, wd0, be0, we0);
    check("lb_stalls", stalls, 2);
    check("lb_addr_be", {addr0[27:0], be0}, {28'h000_0100, 4'hF});
    check("lb_data", LoadData_wb, 32'hFFFF_FF80);
    check("lb_wb", {MemReg_wb, RegWrite_wb, WriteReg_wb}, {2'b01, 1'b1, 5'd9});

    // lbu 0x103
    set_op(1, 1, 0, 2'b10, 1, 32'h0000_0103, 32'h0, 1, 5'd9, 32'h4C);
    run_op(0, 32'h80FF_1122, 0, stalls, reqs, stable, addr0, wd0, be0, we0);
    check("lbu_data", LoadData_wb, 32'h0000_0080);

    // lhu / lh 0x102
    set_op(1, 1, 0, 2'b01, 1, 32'h0000_0102, 32'h0, 1, 5'd10, 32'h50);
    run_op(0, 32'h80FF_1122, 0, stalls, reqs, stable, addr0, wd0, be0, we0);
    check("lhu_data", LoadData_wb, 32'h0000_80FF);
    set_op(1, 1, 0, 2'b01, 0, 32'h0000_0102, 32'h0, 1, 5'd10, 32'h54);
    run_op(0, 32'h80FF_1122, 0, stalls, reqs, stable, addr0, wd0, be0, we0);
    check("lh_data", LoadData_wb, 32'hFFFF_80FF);

    // sh 0x202, ack on 5th ACCESS cycle
    set_op(1, 0, 1, 2'b01, 0, 32'h0000_0202, 32'hDEAD_BEEF, 0, 5'd0, 32'h58);
    run_op(4, 32'h0, 0, stalls, reqs, stable, addr0, wd0, be0, we0);
    check("sh_stalls", stalls, 6);
    check("sh_addr", addr0, 32'h0000_0200);
    check("sh_wdata", wd0, 32'hBEEF_BEEF);
    check("sh_be_we_stable", {26'h0, be0, we0, stable}, {26'h0, 4'b1100, 1'b1, 1'b1});
    check("sh_wb", {LoadData_wb[30:0], RegWrite_wb}, 32'h0);

    // sb 0x201
    set_op(1, 0, 1, 2'b10, 0, 32'h0000_0201, 32'h1234_56A5, 0, 5'd0, 32'h5C);
    run_op(0, 32'h0, 0, stalls, reqs, stable, addr0, wd0, be0, we0);
    check("sb_wdata", wd0, 32'hA5A5_A5A5);
    check("sb_be", {28'h0, be0}, 32'h2);

    // lw with no ack: 15 ACCESS cycles then bus error
    set_op(1, 1, 0, 2'b00, 0, 32'h0000_0300, 32'h0, 1, 5'd11, 32'h60);
    run_op(-1, 32'h5555_5555, 0, stalls, reqs, stable, addr0, wd0, be0, we0);
    check("to_reqs_stalls", {reqs[15:0], stalls[15:0]}, {16'd15, 16'd16});
    check("to_buserr", {31'h0, BusErr}, 32'h1);
    check("to_regwrite_loaddata", {LoadData_wb[30:0], RegWrite_wb}, 32'h0);
    check("to_wb_alu", ALUResult_wb, 32'h300);

    // ALU op after timeout: pipeline resumes, BusErr sticky
    set_op(1, 0, 0, 2'b00, 0, 32'h0000_0077, 32'h0, 1, 5'd3, 32'h64);
    run_op(0, 32'h0, 0, stalls, reqs, stable, addr0, wd0, be0, we0);
    check("resume_wb", {BusErr, RegWrite_wb, ALUResult_wb[7:0]}, {1'b1, 1'b1, 8'h77});

    // Flush during ACCESS of lw: access completes, bubble written back
    set_op(1, 1, 0, 2'b00, 0, 32'h0000_0400, 32'h0, 1, 5'd12, 32'h68);
    run_op(2, 32'hCAFE_F00D, 1, stalls, reqs, stable, addr0, wd0, be0, we0);
    check("flacc_reqs", reqs, 3);
    check("flacc_bubble", {RegWrite_wb, WriteReg_wb, ALUResult_wb[25:0]}, 32'h0);
    check("flacc_loaddata", LoadData_wb, 32'h0);

    // Flush in IDLE on a memory op: no access, bubble
    set_op(1, 1, 0, 2'b00, 0, 32'h0000_0500, 32'h0, 1, 5'd13, 32'h6C);
    Flush = 1'b1;
    run_op(0, 32'h0, 0, stalls, reqs, stable, addr0, wd0, be0, we0);
    Flush = 1'b0;
    check("flidle_stall_req", {stalls[15:0], reqs[15:0]}, 32'h0);
    check("flidle_bubble", {RegWrite_wb, WriteReg_wb, PC_wb[25:0]}, 32'h0);

    // Misaligned lw at 0x6
    set_op(1, 1, 0, 2'b00, 0, 32'h0000_0006, 32'h0, 1, 5'd14, 32'h70);
    run_op(0, 32'h1234_5678, 0, stalls, reqs, stable, addr0, wd0, be0, we0);
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_reqs_stalls", {reqs[15:0], stalls[15:0]}, {16'd0, 16'd1});
    check("mis_flag_regwrite", {30'h0, MisalignErr_MEMWB, RegWrite_wb}, 32'h2);
`else
    check("mis_addr_reqs", {addr0[15:0], reqs[15:0]}, {16'h0004, 16'd1});
    check("mis_flag_regwrite", {30'h0, MisalignErr_MEMWB, RegWrite_wb}, 32'h1);
    check("mis_loaddata", LoadData_wb, 32'h1234_5678);
`endif
    set_op(1, 0, 0, 2'b00, 0, 32'h0000_0006, 32'h0, 1, 5'd14, 32'h74);
    run_op(0, 32'h0, 0, stalls, reqs, stable, addr0, wd0, be0, we0);
    check("mis_clear_next", {30'h0, MisalignErr_MEMWB, RegWrite_wb}, 32'h1);

    // Ack while IDLE is ignored
    dif.DMemAck = 1'b1;
    @(negedge Clk);
    check("ack_idle", {30'h0, Stall_MEM, dif.DMemReq}, 32'h0);
    @(posedge Clk); #1;
    dif.DMemAck = 1'b0;
    @(negedge Clk);
    check("ack_idle_after", {30'h0, Stall_MEM, dif.DMemReq}, 32'h0);

    // Reset mid-ACCESS
    @(posedge Clk); #1;
    set_op(1, 1, 0, 2'b00, 0, 32'h0000_0600, 32'h0, 1, 5'd15, 32'h78);
    @(negedge Clk);
    @(negedge Clk);
    check("rstmid_pre_req", {31'h0, dif.DMemReq}, 32'h1);
    #1 Rst = 1'b1;
    #1;
    check("rstmid_req_be_we", {26'h0, dif.DMemReq, dif.DMemBE, dif.DMemWe}, 32'h0);
    check("rstmid_buserr_wb", {BusErr, RegWrite_wb, ALUResult_wb[29:0]}, 32'h0);
    set_op(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    dif.DMemAck = 1'b1;
    @(negedge Clk);
    check("late_ack_ignored", {29'h0, Stall_MEM, dif.DMemReq, BusErr}, 32'h0);
    dif.DMemAck = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage plus MEM/WB pipeline register.
- Takes EX/MEM controls, address and store data, and runs a req/ack handshake to data memory.
- Formats load data (byte/half/word, signed/unsigned) and registers ALUResult, LoadData, PC2ndAdder, MemReg, RegWrite and WriteReg into MEM/WB for the write-back mux.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- ACK_TIMEOUT, 15: max ACCESS cycles waiting for DMemAck before abandoning the access; counter width is $clog2(ACK_TIMEOUT+1).

Ports:
- Clk  input  1  clock, rising edge
- Rst  input  1  asynchronous, active-high reset
- Valid_EXMEM_MEM  input  1  instruction in EX/MEM is valid
- MemRead_EXMEM_MEM  input  1  load
- MemWrite_EXMEM_MEM  input  1  store
- MemSize_EXMEM_MEM  input  2  00 word, 01 half, 10 byte, 11 treated as word
- LoadUnsigned_EXMEM_MEM  input  1  zero-extend sub-word load
- ALUResult_EXMEM_MEM  input  32  effective address / ALU result
- WriteData_EXMEM_MEM  input  32  store data
- MemReg_EXMEM_MEM  input  2  write-back select, passed through
- RegWrite_EXMEM_MEM  input  1  register write enable
- WriteReg_EXMEM_MEM  input  5  destination register
- PC2ndAdder_EXMEM_MEM  input  32  link address
- Flush_MEM  input  1  turn the current instruction into a bubble
- DMemReq  output  1  memory request
- DMemWe  output  1  1 = write
- DMemAddr  output  32  {ALUResult[31:2],2'b00}
- DMemWData  output  32  lane-replicated store data
- DMemBE  output  4  byte enables
- DMemAck  input  1  access complete; read data valid in the same cycle
- DMemRData  input  32  read word
- Stall_MEM  output  1  hold IF/ID/EX and EX/MEM
- BusErr  output  1  sticky timeout flag
- MisalignErr_MEMWB  output  1  see Optional Feature
- MemReg_MEMWB_WRITE  output  2
- LoadData_MEMWB_WRITE  output  32
- ALUResult_MEMWB_WRITE  output  32
- PC2ndAdder_MEMWB_Write  output  32
- RegWrite_MEMWB_WRITE  output  1
- WriteReg_MEMWB_WRITE  output  5

Behaviour:
- Reset (async, Rst=1): state IDLE; all MEM/WB outputs, DMemReq, DMemWe, DMemBE, BusErr, MisalignErr_MEMWB and timeout counter are 0.
- A memory op is Valid & (MemRead|MemWrite). If both are set, MemWrite wins.
- FSM:
  - IDLE:
    - Non-memory op or invalid instruction: MEM/WB loads next edge (1-cycle latency), Stall_MEM=0.
    - Memory op: Stall_MEM=1 combinationally, go to ACCESS. MEM/WB does not load.
  - ACCESS:
    - DMemReq=1, with DMemWe/DMemAddr/DMemWData/DMemBE driven from the held EX/MEM inputs, stable until ack.
    - Stall_MEM=1.
    - On DMemAck: capture the formatted load data, go to DONE.
    - If the counter reaches ACK_TIMEOUT without an ack: set BusErr, go to DONE with load data 0 and RegWrite forced 0.
  - DONE: Stall_MEM=0, MEM/WB loads, go to IDLE.
  - Minimum memory-op latency: 3 cycles (ack on the first ACCESS cycle), i.e. 2 stall cycles.
- Store lanes (little-endian):
  - Byte: BE=1<<addr[1:0], data byte replicated ×4.
  - Half: BE=addr[1]?1100:0011, halfword replicated ×2.
  - Word: BE=1111.
  - Loads: BE=1111.
- Load format:
  - Byte selects lane addr[1:0]; half selects addr[1].
  - Sign- or zero-extend per LoadUnsigned.
  - Non-load ops: LoadData=0.
- Flush_MEM:
  - In IDLE: MEM/WB loads a bubble (RegWrite=0, WriteReg=0, all else 0). No access starts.
  - In ACCESS: the access still completes (a bus transaction is never aborted); a latched flush flag makes DONE load a bubble.
- Reset mid-ACCESS: DMemReq drops immediately. Any late DMemAck is ignored in IDLE.
- DMemAck seen in IDLE or DONE: ignored.
- BusErr is cleared only by Rst.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠00, is misaligned.
  - No request is issued. IDLE goes straight to DONE (1 stall cycle).
  - MEM/WB loads with RegWrite=0 and MisalignErr_MEMWB=1 for that instruction; MisalignErr_MEMWB is 0 for all others.
- Undefined: the low address bits beyond the access size are ignored, and MisalignErr_MEMWB is tied to 0.

Test Plan:
- ALU op (Valid=1, MemRead=MemWrite=0, ALUResult=0x0000_1234, RegWrite=1, WriteReg=8) -> next edge ALUResult_MEMWB_WRITE=0x1234, RegWrite=1, Stall_MEM never asserted.
- lb at 0x103, DMemRData=0x80FF_1122, ack on the 1st ACCESS cycle -> Stall_MEM high 2 cycles, LoadData=0xFFFF_FF80. Same with LoadUnsigned=1 -> 0x0000_0080. lhu at 0x102 -> 0x0000_80FF.
- sh at 0x202 with WriteData=0xDEAD_BEEF, ack delayed 4 cycles -> DMemAddr=0x200, BE=1100, DMemWData=0xBEEF_BEEF held stable, DMemWe=1, Stall_MEM high 6 cycles.
- lw with no ack and ACK_TIMEOUT=15 -> after 15 ACCESS cycles BusErr=1, RegWrite_MEMWB=0, pipeline resumes. BusErr stays 1 until Rst.
- Flush_MEM pulsed during ACCESS of lw -> access completes on ack, MEM/WB gets a bubble (RegWrite=0). Rst asserted mid-ACCESS -> DMemReq=0 and all outputs 0 asynchronously.
- With MEM_ALIGN_CHECK_EN defined: lw at 0x0000_0006 -> DMemReq never asserts, MisalignErr_MEMWB=1, RegWrite=0. With the macro undefined -> access proceeds at 0x4.
